i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- Standalone I2C target (slave) that answers a real two-wire bus driven by an external I2C controller.
- Oversamples SCL/SDA on the system clock, detects START/STOP/repeated START, matches a 7-bit device address and ACKs it.
- Serves a byte-addressable register memory with an auto-incrementing pointer.
- Drives SDA open-drain only, through an output-enable; sits between the pad ring and on-chip register consumers.

Parameters:
- DEV_ADDR, 7'h50, 7-bit bus address the block responds to.
- DEPTH, 128, number of 8-bit register locations; pointer is $clog2(DEPTH) bits and wraps modulo DEPTH.
- SYNC_STAGES, 2, flip-flop synchronizer depth on scl_i and sda_i.

Ports:
- clk  input  1  system clock; must be at least 8x SCL frequency.
- rstn  input  1  reset, asynchronous, active-low.
- scl_i  input  1  bus SCL level, asynchronous.
- sda_i  input  1  bus SDA level, asynchronous.
- sda_oe  output  1  1 = pull SDA low; 0 = release. Pad drives 0 when set.
- busy  output  1  high from an address-matched START until STOP, NACKed read, or address mismatch.
- wr_valid  output  1  one-clk pulse when a data byte is committed to memory.
- wr_ptr  output  $clog2(DEPTH)  location written; valid with wr_valid.
- wr_data  output  8  byte written; valid with wr_valid.

Behaviour:
- Reset (async): sda_oe=0, busy=0, wr_valid=0, wr_ptr=0, wr_data=0, pointer=0, all memory=0, state=IDLE. Reset mid-transfer releases SDA immediately.
- Synchronize scl_i and sda_i through SYNC_STAGES flops, plus one history flop each.
  - scl_rise / scl_fall: single-clk edge strobes.
  - START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while synced SCL is high.
- START or STOP is recognised in every state and takes priority over bit activity in the same clk.
  - START (including repeated START): bit counter cleared, sda_oe=0, go to ADDR.
  - STOP: sda_oe=0, busy=0, go to IDLE.
- Bit rules: SDA is sampled on scl_rise, MSB first. sda_oe changes only on scl_fall; latency is 1 clk after the synced edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W, 1 = read).
    - Match: on the next scl_fall assert sda_oe and busy, go to ADDR_ACK.
    - Mismatch: go to WAIT_STOP, never drive.
  - ADDR_ACK: on the scl_fall ending the ACK bit, release SDA.
    - Write: go to PTR.
    - Read: load shift register = mem[pointer], drive bit7 (sda_oe = ~bit), go to RDATA.
  - PTR: shift 8 bits; pointer = byte modulo DEPTH; ACK as above; go to PTR_ACK, then WDATA.
  - WDATA: shift 8 bits. On the 8th scl_rise, mem[pointer]=byte, pulse wr_valid with wr_ptr/wr_data. Pointer increments (wraps). ACK; go to WDATA_ACK, then WDATA.
  - RDATA: on each scl_fall present the next bit. After bit0's scl_fall, release SDA, increment pointer (wraps), go to RDATA_ACK.
  - RDATA_ACK: sample controller ACK on scl_rise.
    - 0: reload from mem[pointer] and drive bit7 on the next scl_fall; go to RDATA.
    - 1 (NACK): busy=0, go to WAIT_STOP.
  - WAIT_STOP: sda_oe=0; wait for START or STOP.
- General-call address 0x00 is not acknowledged.
- The pointer persists across transactions; write-pointer then repeated-START read returns that location.
- A STOP mid-byte discards the partial byte: no memory write, no wr_valid.
- sda_oe is never asserted outside the ACK slots and read-data bits.

Test Plan:
- Write: START, 0xA0, ptr 0x10, data 0xA5, 0x3C, STOP -> ACK on all 4 bytes; wr_valid twice (0x10/0xA5, 0x11/0x3C); busy falls after STOP.
- Combined read: START, 0xA0, ptr 0x10, repeated START, 0xA1, read 2 bytes (ACK, then NACK) -> target shifts 0xA5 then 0x3C; sda_oe released after NACK.
- Address mismatch: START, 0xA2, 0x55, STOP -> sda_oe stays 0 throughout; no wr_valid; busy stays 0.
- Wrap: write ptr 0x7F, data 0x11, 0x22 -> wr_ptr 0x7F then 0x00; read from 0x7F returns 0x11, 0x22.
- Abort: STOP after 4 data bits of a write -> no wr_valid; memory unchanged; next transaction ACKs normally.
- Reset: assert rstn low during read-data bit 3 -> sda_oe=0 within the same clk; all outputs at reset values; memory reads back 0x00.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target with 7-bit address match and an auto-incrementing byte register file.
// SCL/SDA are oversampled on clk; SDA is driven open-drain through sda_oe.
`timescale 1ns/1ps
module i2c_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         DEPTH       = 128,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     scl_i,
  input  logic                     sda_i,
  output logic                     sda_oe,
  output logic                     busy,
  output logic                     wr_valid,
  output logic [$clog2(DEPTH)-1:0] wr_ptr,
  output logic [7:0]               wr_data
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_PTR       = 4'd3;
  localparam logic [3:0] S_PTR_ACK   = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RDATA_ACK = 4'd8;
  localparam logic [3:0] S_WAIT_STOP = 4'd9;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_d, sda_d;
  logic                   scl_s, sda_s;
  logic                   scl_rise, scl_fall, start_det, stop_det;

  logic [3:0]    state;
  logic [3:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    shift_in;
  logic          rw;
  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_inc;
  logic          addr_match;
  logic [7:0]    mem [DEPTH];

  // Synchronizers reset to the idle-bus level so release of reset cannot look like an edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;

  assign shift_in   = {shift[6:0], sda_s};
  assign addr_match = (shift[7:1] == DEV_ADDR) && (shift[7:1] != 7'd0);
  assign ptr_inc    = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      bit_cnt  <= 4'd0;
      shift    <= 8'h00;
      rw       <= 1'b0;
      ptr      <= '0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      wr_valid <= 1'b0;
      wr_ptr   <= '0;
      wr_data  <= 8'h00;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      wr_valid <= 1'b0;
      if (start_det) begin
        state   <= S_ADDR;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_ADDR: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shift   <= shift_in;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              if (addr_match) begin
                sda_oe <= 1'b1;
                busy   <= 1'b1;
                rw     <= shift[0];
                state  <= S_ADDR_ACK;
              end else begin
                busy  <= 1'b0;
                state <= S_WAIT_STOP;
              end
            end
          end
          S_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 4'd0;
              if (rw) begin
                shift  <= mem[ptr];
                sda_oe <= ~mem[ptr][7];
                state  <= S_RDATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= S_PTR;
              end
            end
          end
          S_PTR: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shift   <= shift_in;
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              ptr    <= PW'(shift % DEPTH);
              sda_oe <= 1'b1;
              state  <= S_PTR_ACK;
            end
          end
          S_PTR_ACK, S_WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= S_WDATA;
            end
          end
          S_WDATA: begin
            // Commit on the 8th rising edge; a STOP before then leaves memory untouched.
            if (scl_rise && bit_cnt < 4'd8) begin
              shift   <= shift_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                mem[ptr] <= shift_in;
                wr_valid <= 1'b1;
                wr_ptr   <= ptr;
                wr_data  <= shift_in;
                ptr      <= ptr_inc;
              end
            end else if (scl_fall && bit_cnt == 4'd8) begin
              sda_oe <= 1'b1;
              state  <= S_WDATA_ACK;
            end
          end
          S_RDATA: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd7) begin
                sda_oe <= 1'b0;
                ptr    <= ptr_inc;
                state  <= S_RDATA_ACK;
              end else begin
                sda_oe  <= ~shift[6];
                shift   <= {shift[6:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          S_RDATA_ACK: begin
            // A NACK on the rising edge leaves before the fall, so reaching the fall means ACK.
            if (scl_rise && sda_s) begin
              busy  <= 1'b0;
              state <= S_WAIT_STOP;
            end else if (scl_fall) begin
              shift   <= mem[ptr];
              sda_oe  <= ~mem[ptr][7];
              bit_cnt <= 4'd0;
              state   <= S_RDATA;
            end
          end
          S_WAIT_STOP: sda_oe <= 1'b0;
          default: begin
            state  <= S_IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: bit-banged I2C controller, wired-AND SDA,
// scoreboard queues for committed writes and read-back bytes.
`timescale 1ns/1ps
module tb_i2c_target;

  localparam int Q = 100;  // quarter SCL period in ns (clk is 10 ns)

  typedef struct packed {
    logic [6:0] p;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       scl_ctrl = 1'b1;
  logic       sda_ctrl = 1'b1;
  logic       sda_line;
  logic       sda_oe, busy, wr_valid;
  logic [6:0] wr_ptr;
  logic [7:0] wr_data;

  int n_checks = 0;
  int n_fail = 0;

  wr_t        wr_q [$];
  logic [7:0] rd_q [$];
  int         wr_pushed = 0;
  int         wr_drained = 0;

  logic [6:0] obs_ptr  [64];
  logic [7:0] obs_data [64];
  int         obs_cnt = 0;
  int         oe_cnt = 0;
  int         busy_cnt = 0;

  assign sda_line = sda_ctrl & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target #(
    .DEV_ADDR   (7'h50),
    .DEPTH      (128),
    .SYNC_STAGES(2)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .scl_i   (scl_ctrl),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .wr_valid(wr_valid),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_data)
  );

  always @(negedge clk) begin
    if (wr_valid && obs_cnt < 64) begin
      obs_ptr[obs_cnt]  <= wr_ptr;
      obs_data[obs_cnt] <= wr_data;
      obs_cnt           <= obs_cnt + 1;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  initial begin
    #800us;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic i2c_start();
    sda_ctrl = 1'b1; #Q;
    scl_ctrl = 1'b1; #Q;
    sda_ctrl = 1'b0; #Q;
    scl_ctrl = 1'b0; #Q;
  endtask

  task automatic i2c_stop();
    sda_ctrl = 1'b0; #Q;
    scl_ctrl = 1'b1; #Q;
    sda_ctrl = 1'b1; #Q;
  endtask

  task automatic wr_bit(input logic b);
    sda_ctrl = b; #Q;
    scl_ctrl = 1'b1; #Q;
    #Q;
    scl_ctrl = 1'b0; #Q;
  endtask

  task automatic rd_bit(output logic b);
    sda_ctrl = 1'b1; #Q;
    scl_ctrl = 1'b1; #Q;
    b = sda_line; #Q;
    scl_ctrl = 1'b0; #Q;
  endtask

  task automatic send(input string tag, input logic [7:0] data, input logic exp_ack);
    logic ack;
    for (int i = 7; i >= 0; i--) wr_bit(data[i]);
    rd_bit(ack);
    check(tag, ack, exp_ack);
  endtask

  task automatic expect_write(input logic [6:0] p, input logic [7:0] d);
    wr_t e;
    e.p = p;
    e.d = d;
    wr_q.push_back(e);
    wr_pushed++;
  endtask

  // Compare every committed write seen since the last call against the queue.
  task automatic drain_wr(input string tag);
    wr_t e;
    check({tag, "_wr_count"}, obs_cnt, wr_pushed);
    while (wr_drained < obs_cnt && wr_q.size() > 0) begin
      e = wr_q.pop_front();
      check({tag, "_wr_ptr"}, obs_ptr[wr_drained], e.p);
      check({tag, "_wr_data"}, obs_data[wr_drained], e.d);
      wr_drained++;
    end
  endtask

  task automatic rd_check(input string tag, input logic nack);
    logic [7:0] got;
    logic [7:0] exp;
    logic       b;
    exp = rd_q.pop_front();
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      got[i] = b;
    end
    wr_bit(nack);
    check(tag, got, exp);
  endtask

  initial begin
    logic b;
    int   oe_base, busy_base;

    repeat (5) @(negedge clk);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_ptr", wr_ptr, 0);
    check("rst_wr_data", wr_data, 0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // Write two bytes at 0x10
    i2c_start();
    send("w_addr_ack", 8'hA0, 1'b0);
    send("w_ptr_ack", 8'h10, 1'b0);
    expect_write(7'h10, 8'hA5);
    send("w_d0_ack", 8'hA5, 1'b0);
    expect_write(7'h11, 8'h3C);
    send("w_d1_ack", 8'h3C, 1'b0);
    check("w_busy", busy, 1);
    i2c_stop();
    #(4*Q);
    check("w_busy_after_stop", busy, 0);
    drain_wr("write");

    // Combined read with repeated START
    i2c_start();
    send("r_addr_ack", 8'hA0, 1'b0);
    send("r_ptr_ack", 8'h10, 1'b0);
    i2c_start();
    send("r_raddr_ack", 8'hA1, 1'b0);
    rd_q.push_back(8'hA5);
    rd_check("r_d0", 1'b0);
    rd_q.push_back(8'h3C);
    rd_check("r_d1", 1'b1);
    check("r_oe_after_nack", sda_oe, 0);
    check("r_busy_after_nack", busy, 0);
    i2c_stop();
    #(4*Q);

    // Address mismatch and general call: never driven, never busy
    oe_base   = oe_cnt;
    busy_base = busy_cnt;
    i2c_start();
    send("m_addr_nack", 8'hA2, 1'b1);
    send("m_data_nack", 8'h55, 1'b1);
    i2c_stop();
    i2c_start();
    send("gc_addr_nack", 8'h00, 1'b1);
    i2c_stop();
    #(4*Q);
    check("m_oe_cycles", oe_cnt - oe_base, 0);
    check("m_busy_cycles", busy_cnt - busy_base, 0);
    drain_wr("mismatch");

    // Pointer wrap on write and read
    i2c_start();
    send("wr_addr_ack", 8'hA0, 1'b0);
    send("wr_ptr_ack", 8'h7F, 1'b0);
    expect_write(7'h7F, 8'h11);
    send("wr_d0_ack", 8'h11, 1'b0);
    expect_write(7'h00, 8'h22);
    send("wr_d1_ack", 8'h22, 1'b0);
    i2c_stop();
    #(4*Q);
    drain_wr("wrap");
    i2c_start();
    send("wrr_addr_ack", 8'hA0, 1'b0);
    send("wrr_ptr_ack", 8'h7F, 1'b0);
    i2c_start();
    send("wrr_raddr_ack", 8'hA1, 1'b0);
    rd_q.push_back(8'h11);
    rd_check("wrr_d0", 1'b0);
    rd_q.push_back(8'h22);
    rd_check("wrr_d1", 1'b1);
    i2c_stop();
    #(4*Q);

    // STOP after 4 data bits discards the byte
    i2c_start();
    send("ab_addr_ack", 8'hA0, 1'b0);
    send("ab_ptr_ack", 8'h20, 1'b0);
    wr_bit(1'b1);
    wr_bit(1'b0);
    wr_bit(1'b1);
    wr_bit(1'b0);
    i2c_stop();
    #(4*Q);
    drain_wr("abort");
    i2c_start();
    send("ab2_addr_ack", 8'hA0, 1'b0);
    send("ab2_ptr_ack", 8'h20, 1'b0);
    i2c_start();
    send("ab2_raddr_ack", 8'hA1, 1'b0);
    rd_q.push_back(8'h00);
    rd_check("ab2_d0", 1'b1);
    i2c_stop();
    #(4*Q);

    // Reset while the target drives read bit 3 (0xA5 bit 3 is 0)
    i2c_start();
    send("rs_addr_ack", 8'hA0, 1'b0);
    send("rs_ptr_ack", 8'h10, 1'b0);
    i2c_start();
    send("rs_raddr_ack", 8'hA1, 1'b0);
    for (int i = 0; i < 4; i++) rd_bit(b);
    check("rs_pre_oe", sda_oe, 1);
    rstn = 1'b0;
    #1;
    check("rs_sda_oe", sda_oe, 0);
    check("rs_busy", busy, 0);
    check("rs_wr_valid", wr_valid, 0);
    check("rs_wr_ptr", wr_ptr, 0);
    check("rs_wr_data", wr_data, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    i2c_stop();
    #(4*Q);
    i2c_start();
    send("rs_cur_addr_ack", 8'hA1, 1'b0);
    rd_q.push_back(8'h00);
    rd_check("rs_mem0", 1'b1);
    i2c_stop();
    i2c_start();
    send("rs2_addr_ack", 8'hA0, 1'b0);
    send("rs2_ptr_ack", 8'h10, 1'b0);
    i2c_start();
    send("rs2_raddr_ack", 8'hA1, 1'b0);
    rd_q.push_back(8'h00);
    rd_check("rs_mem10", 1'b1);
    i2c_stop();
    #(4*Q);

    drain_wr("final");
    check("wr_q_left", wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
